decoder3_8_strobe: RTL

Registered 3-to-8 decoder with a valid/ready input handshake and a timed one-hot output strobe. It accepts a 3-bit binary code, drives the matching one-hot line of `out` for a fixed number of cycles, then enforces a gap before accepting the next code. The block sits on the return path of the 8-to-3 encoder: encoded selections are expanded back to one-hot lines that drive lamps, enables or chip selects.

---
 rtl/dec38_pkg.sv | 17 +
 rtl/dec38_onehot.sv | 9 +
 rtl/decoder3_8_strobe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dec38_pkg.sv
// Shared types and limits for the registered 3-to-8 strobe decoder.
package dec38_pkg;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned HOLD_MIN = 1;
    localparam int unsigned HOLD_MAX = 255;
    localparam int unsigned GAP_MAX  = 255;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dec38_onehot.sv
// Combinational 3-to-8 one-hot expander.
module dec38_onehot (
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    assign onehot = 8'(1) << sel;

endmodule

// File: rtl/decoder3_8_strobe.sv
// Registered 3-to-8 decoder with valid/ready intake, timed one-hot strobe and gap.
// Optional even-parity check on the code is enabled with DEC38_PARITY_EN.
module decoder3_8_strobe
    import dec38_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       CP,
    input  logic       RST,
    input  logic [2:0] CODE,
    input  logic       VALID,
    output logic       READY,
    output logic [7:0] out,
    output logic       BUSY,
    output logic       DONE
`ifdef DEC38_PARITY_EN
    ,
    input  logic       PAR,
    output logic       ERR
`endif
);

    state_t     state;
    cnt_t       cnt;
    logic [2:0] code_q;
    logic [2:0] sel;
    logic [7:0] onehot;
    logic       accept;
    logic       code_ok;

    if (HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > HOLD_MAX || GAP_CYCLES > GAP_MAX) begin : g_bad_param
        $error("decoder3_8_strobe: HOLD_CYCLES or GAP_CYCLES out of range");
    end

    assign READY  = (state == IDLE);
    assign accept = VALID && READY;

`ifdef DEC38_PARITY_EN
    assign code_ok = ~^{PAR, CODE};
`else
    assign code_ok = 1'b1;
`endif

    // Expand the incoming code at accept, the latched code while holding.
    assign sel = (state == IDLE) ? CODE : code_q;

    dec38_onehot u_onehot (
        .sel    (sel),
        .onehot (onehot)
    );

    always_ff @(posedge CP) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            code_q <= '0;
            out    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
`ifdef DEC38_PARITY_EN
            ERR    <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
`ifdef DEC38_PARITY_EN
            ERR  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (code_ok) begin
                            state  <= HOLD;
                            code_q <= CODE;
                            out    <= onehot;
                            cnt    <= CNT_W'(HOLD_CYCLES - 1);
                            BUSY   <= 1'b1;
                        end
`ifdef DEC38_PARITY_EN
                        else begin
                            ERR <= 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        out <= onehot;
                    end else if (GAP_CYCLES > 0) begin
                        state <= GAP;
                        out   <= '0;
                        cnt   <= CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        state <= IDLE;
                        out   <= '0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= '0;
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
